// File: rtl/bch_pkg.sv
// bch_pkg: GF(16) types, controller state encoding and constant multipliers for the BCH(15,7) decoder
package bch_pkg;
  localparam int GF_M = 4;
  localparam int GF_N = 15;
  typedef logic [GF_M-1:0] gf_t;
  typedef enum logic [1:0] {IDLE, LOAD, CHIEN, DONE} state_e;
  // x*alpha modulo x^4+x+1
  function automatic gf_t gf_mul_alpha(input gf_t x);
    return {x[2], x[1], x[0] ^ x[3], x[3]};
  endfunction
  // x*alpha^2 modulo x^4+x+1
  function automatic gf_t gf_mul_alpha2(input gf_t x);
    return {x[1], x[0] ^ x[3], x[3] ^ x[2], x[2]};
  endfunction
endpackage

// File: rtl/bch_chien_cell.sv
// bch_chien_cell: locator term registers for the serial Chien search
//   clk, rst_n : clock, async active-low reset
//   load       : capture l1/l2 as the i=0 terms
//   step       : advance terms to the next field element (r1*alpha, r2*alpha^2)
//   l1, l2     : locator coefficients
//   root       : 1 ^ r1 ^ r2 == 0 for the current element
module bch_chien_cell
  import bch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  input  gf_t  l1,
  input  gf_t  l2,
  output logic root
);
  gf_t r1_q, r1_d, r2_q, r2_d;
  always_comb begin
    r1_d = load ? l1 : step ? gf_mul_alpha(r1_q) : r1_q;
    r2_d = load ? l2 : step ? gf_mul_alpha2(r2_q) : r2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
    end
  end
  assign root = (4'h1 ^ r1_q ^ r2_q) == 4'h0;
endmodule

// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl: sequencer for the t=2 BCH(15,7) decoder (syndrome screen, locator capture, Chien search)
//   syn_valid/syn_ready, syn_s1..s3 : syndrome input handshake
//   loc_s1..s3 / loc_l1, loc_l2    : registered syndromes out, combinational locator coefficients back
//   out_valid/out_ready, err_mask, err_num, dec_fail : result handshake
//   busy                           : not idle
//   BCH_ERR_CNT_EN adds cnt_ok, cnt_corr, cnt_fail (saturating, CNT_W bits)
module bch_dec_ctrl
  import bch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syn_valid,
  output logic              syn_ready,
  input  logic [3:0]        syn_s1,
  input  logic [3:0]        syn_s2,
  input  logic [3:0]        syn_s3,
  output logic [3:0]        loc_s1,
  output logic [3:0]        loc_s2,
  output logic [3:0]        loc_s3,
  input  logic [3:0]        loc_l1,
  input  logic [3:0]        loc_l2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GF_N-1:0]   err_mask,
  output logic [1:0]        err_num,
  output logic              dec_fail,
  output logic              busy
`ifdef BCH_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_ok,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_fail
`endif
);
  state_e state_q, state_d;
  gf_t loc_s1_q, loc_s1_d, loc_s2_q, loc_s2_d, loc_s3_q, loc_s3_d;
  logic [3:0] i_q, i_d, bit_idx;
  logic [1:0] deg_q, deg_d, root_cnt_q, root_cnt_d;
  logic [GF_N-1:0] mask_q, mask_d, err_mask_q, err_mask_d;
  logic [1:0] err_num_q, err_num_d;
  logic dec_fail_q, dec_fail_d;
  logic accept, screened, root, root_hit, fin, deg_ok;
  bch_chien_cell u_chien (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q == LOAD),
    .step  (state_q == CHIEN),
    .l1    (loc_l1),
    .l2    (loc_l2),
    .root  (root)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = accept ? (screened ? DONE : LOAD) : IDLE;
      LOAD:  state_d = CHIEN;
      CHIEN: state_d = (i_q == 4'd14) ? DONE : CHIEN;
      DONE:  state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    syn_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    out_valid = state_q == DONE;
  end
  always_comb begin
    accept     = syn_valid && syn_ready;
    screened   = syn_s1 == 4'h0;
    loc_s1_d   = accept ? syn_s1 : loc_s1_q;
    loc_s2_d   = accept ? syn_s2 : loc_s2_q;
    loc_s3_d   = accept ? syn_s3 : loc_s3_q;
    deg_d      = (state_q == LOAD) ? ((loc_l2 != 4'h0) ? 2'd2 : 2'd1) : deg_q;
    i_d        = (state_q == LOAD) ? 4'd0 : (state_q == CHIEN) ? i_q + 4'd1 : i_q;
    // element alpha^i is a root for error position (15-i) mod 15
    bit_idx    = (i_q == 4'd0) ? 4'd0 : 4'd15 - i_q;
    root_hit   = (state_q == CHIEN) && root;
    root_cnt_d = (state_q == LOAD) ? 2'd0 :
                 root_hit ? ((root_cnt_q == 2'd3) ? 2'd3 : root_cnt_q + 2'd1) : root_cnt_q;
    mask_d     = (state_q == LOAD) ? '0 : root_hit ? (mask_q | (GF_N'(1) << bit_idx)) : mask_q;
    fin        = (state_q == CHIEN) && (i_q == 4'd14);
    // a locator whose degree disagrees with its root count means more than two errors
    deg_ok     = root_cnt_d == deg_q;
    err_mask_d = (accept && screened) ? '0 : fin ? (deg_ok ? mask_d : '0) : err_mask_q;
    err_num_d  = (accept && screened) ? 2'd0 : fin ? (deg_ok ? root_cnt_d : 2'd0) : err_num_q;
    dec_fail_d = (accept && screened) ? (syn_s3 != 4'h0) : fin ? !deg_ok : dec_fail_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_s1_q   <= '0;
      loc_s2_q   <= '0;
      loc_s3_q   <= '0;
      i_q        <= '0;
      deg_q      <= '0;
      root_cnt_q <= '0;
      mask_q     <= '0;
      err_mask_q <= '0;
      err_num_q  <= '0;
      dec_fail_q <= 1'b0;
    end else begin
      loc_s1_q   <= loc_s1_d;
      loc_s2_q   <= loc_s2_d;
      loc_s3_q   <= loc_s3_d;
      i_q        <= i_d;
      deg_q      <= deg_d;
      root_cnt_q <= root_cnt_d;
      mask_q     <= mask_d;
      err_mask_q <= err_mask_d;
      err_num_q  <= err_num_d;
      dec_fail_q <= dec_fail_d;
    end
  end
  assign loc_s1   = loc_s1_q;
  assign loc_s2   = loc_s2_q;
  assign loc_s3   = loc_s3_q;
  assign err_mask = err_mask_q;
  assign err_num  = err_num_q;
  assign dec_fail = dec_fail_q;
`ifdef BCH_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_corr_q, cnt_corr_d, cnt_fail_q, cnt_fail_d;
  logic hs;
  assign hs = out_valid && out_ready;
  always_comb begin
    cnt_ok_d   = (hs && err_num_q == 2'd0 && !dec_fail_q && !(&cnt_ok_q)) ? cnt_ok_q + CNT_W'(1) : cnt_ok_q;
    cnt_corr_d = (hs && err_num_q != 2'd0 && !(&cnt_corr_q)) ? cnt_corr_q + CNT_W'(1) : cnt_corr_q;
    cnt_fail_d = (hs && dec_fail_q && !(&cnt_fail_q)) ? cnt_fail_q + CNT_W'(1) : cnt_fail_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q   <= '0;
      cnt_corr_q <= '0;
      cnt_fail_q <= '0;
    end else begin
      cnt_ok_q   <= cnt_ok_d;
      cnt_corr_q <= cnt_corr_d;
      cnt_fail_q <= cnt_fail_d;
    end
  end
  assign cnt_ok   = cnt_ok_q;
  assign cnt_corr = cnt_corr_q;
  assign cnt_fail = cnt_fail_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_bch_dec_ctrl.sv
// tb_bch_dec_ctrl: directed vectors for bch_dec_ctrl with hand-computed GF(16) results
module tb_bch_dec_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic syn_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] syn_s1 = '0, syn_s2 = '0, syn_s3 = '0, loc_l1 = '0, loc_l2 = '0;
  logic syn_ready, out_valid, dec_fail, busy;
  logic [3:0] loc_s1, loc_s2, loc_s3;
  logic [14:0] err_mask;
  logic [1:0] err_num;
`ifdef BCH_ERR_CNT_EN
  logic [15:0] cnt_ok, cnt_corr, cnt_fail;
`endif
  int n_checks = 0, n_errors = 0;
  typedef struct packed {
    logic [3:0] s1, s2, s3, l1, l2;
    int lat;
    logic [14:0] mask;
    logic [1:0] num;
    logic fail;
  } vec_t;
  vec_t vecs [7];

  bch_dec_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_s1    (syn_s1),
    .syn_s2    (syn_s2),
    .syn_s3    (syn_s3),
    .loc_s1    (loc_s1),
    .loc_s2    (loc_s2),
    .loc_s3    (loc_s3),
    .loc_l1    (loc_l1),
    .loc_l2    (loc_l2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_mask  (err_mask),
    .err_num   (err_num),
    .dec_fail  (dec_fail),
    .busy      (busy)
`ifdef BCH_ERR_CNT_EN
    ,
    .cnt_ok    (cnt_ok),
    .cnt_corr  (cnt_corr),
    .cnt_fail  (cnt_fail)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] s1, s2, s3, l1, l2);
    syn_valid = 1'b1;
    syn_s1 = s1; syn_s2 = s2; syn_s3 = s3;
    loc_l1 = l1; loc_l2 = l2;
    @(posedge clk); #1;
    syn_valid = 1'b0;
    syn_s1 = ~s1; syn_s2 = ~s2; syn_s3 = ~s3;
    check("loc_s", {loc_s1, loc_s2, loc_s3}, {s1, s2, s3});
    check("busy", busy, 1);
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        loc_l1 = 4'hF;
        loc_l2 = 4'hF;
      end
    end
    check({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic consume(input logic [14:0] mask);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid", out_valid, 0);
    check("hs_ready", syn_ready, 1);
    check("hs_mask_hold", err_mask, mask);
  endtask

  initial begin
    vecs = '{
      '{4'h8, 4'hC, 4'hA, 4'h8, 4'h0, 16, 15'h0008, 2'd1, 1'b0},
      '{4'h7, 4'h6, 4'h0, 4'h7, 4'h6, 16, 15'h0021, 2'd2, 1'b0},
      '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  0, 15'h0000, 2'd0, 1'b0},
      '{4'h0, 4'h0, 4'h5, 4'h0, 4'h0,  0, 15'h0000, 2'd0, 1'b1},
      '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 16, 15'h0000, 2'd0, 1'b1},
      '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 16, 15'h0001, 2'd1, 1'b0},
      '{4'h9, 4'hD, 4'hF, 4'h9, 4'h0, 16, 15'h4000, 2'd1, 1'b0}
    };
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", syn_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", {err_mask, err_num, dec_fail}, 0);
    check("rst_loc", {loc_s1, loc_s2, loc_s3}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(4'h8, 4'hC, 4'hA, 4'h8, 4'h0);
    wait_valid(16, "bp");
    syn_valid = 1'b1;
    syn_s1 = 4'h0; syn_s2 = 4'h0; syn_s3 = 4'h0;
    loc_l1 = 4'h0; loc_l2 = 4'h0;
    repeat (20) @(posedge clk);
    #1;
    check("bp_valid", out_valid, 1);
    check("bp_ready", syn_ready, 0);
    check("bp_out", {err_mask, err_num, dec_fail}, {15'h0008, 2'd1, 1'b0});
    check("bp_loc", {loc_s1, loc_s2, loc_s3}, 12'h8CA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_ready", syn_ready, 1);
    @(posedge clk); #1;
    syn_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_loc", {loc_s1, loc_s2, loc_s3}, 0);
    check("bp_next_out", {err_mask, err_num, dec_fail}, 0);
    consume(15'h0);

    foreach (vecs[k]) begin
      send(vecs[k].s1, vecs[k].s2, vecs[k].s3, vecs[k].l1, vecs[k].l2);
      wait_valid(vecs[k].lat, $sformatf("v%0d", k));
      check($sformatf("v%0d_mask", k), err_mask, vecs[k].mask);
      check($sformatf("v%0d_num", k), err_num, vecs[k].num);
      check($sformatf("v%0d_fail", k), dec_fail, vecs[k].fail);
      consume(vecs[k].mask);
    end

`ifdef BCH_ERR_CNT_EN
    check("cnt_ok", cnt_ok, 2);
    check("cnt_corr", cnt_corr, 5);
    check("cnt_fail", cnt_fail, 2);
`endif
    send(4'h8, 4'hC, 4'hA, 4'h8, 4'h0);
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    check("mid_valid", out_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ready", syn_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_valid", out_valid, 0);
    check("mr_out", {err_mask, err_num, dec_fail}, 0);
    check("mr_loc", {loc_s1, loc_s2, loc_s3}, 0);
`ifdef BCH_ERR_CNT_EN
    check("mr_cnt", {cnt_ok, cnt_corr, cnt_fail}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int stale = 0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk); #1;
        if (out_valid) stale++;
      end
      check("mr_stale_valid", stale, 0);
    end
    check("mr_ready_after", syn_ready, 1);
    send(4'h7, 4'h6, 4'h0, 4'h7, 4'h6);
    wait_valid(16, "post");
    check("post_out", {err_mask, err_num, dec_fail}, {15'h0021, 2'd2, 1'b0});
    consume(15'h0021);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
